// File: rtl/maxp_loop_gen_pkg.sv
// Shared constants for the max-pool loop-index generator: FSM encodings and width defaults.
package maxp_loop_gen_pkg;

  localparam int unsigned DATA_SIZE_DEF = 16;
  localparam int unsigned LOOP_BIT_DEF  = 12;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/maxp_win_cnt.sv
// Window-origin counter: steps an origin by `step` until origin+step exceeds `limit`,
// then wraps to `init`; keeps a parallel output index counting the steps.
module maxp_win_cnt #(
  parameter int unsigned CW = 18,
  parameter int unsigned LB = 12
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic          adv,
  input  logic [CW-1:0] init,
  input  logic [CW-1:0] step,
  input  logic [CW-1:0] limit,
  output logic [CW-1:0] value,
  output logic [LB-1:0] idx,
  output logic          wrap_c
);

  logic [CW-1:0] value_q, value_d;
  logic [LB-1:0] idx_q, idx_d;

  // limit is pre-reduced by the window size, so this is origin+step+win > extent
  assign wrap_c = (value_q + step) > limit;

  always_comb begin
    value_d = value_q;
    idx_d   = idx_q;
    if (load) begin
      value_d = init;
      idx_d   = '0;
    end else if (adv) begin
      if (wrap_c) begin
        value_d = init;
        idx_d   = '0;
      end else begin
        value_d = value_q + step;
        idx_d   = idx_q + LB'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      value_q <= '0;
      idx_q   <= '0;
    end else begin
      value_q <= value_d;
      idx_q   <= idx_d;
    end
  end

  assign value = value_q;
  assign idx   = idx_q;

endmodule

// File: rtl/maxp_loop_gen.sv
// Handshaked loop-index generator for max-pool: map -> out row -> out col -> win row -> win col,
// one tuple per accepted beat, with config validation and a done pulse.
module maxp_loop_gen
  import maxp_loop_gen_pkg::*;
#(
  parameter int unsigned DATA_SIZE = DATA_SIZE_DEF,
  parameter int unsigned LOOP_BIT  = LOOP_BIT_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [DATA_SIZE-1:0] M,
  input  logic [DATA_SIZE-1:0] nIR,
  input  logic [DATA_SIZE-1:0] nIC,
  input  logic [DATA_SIZE-1:0] nP,
  input  logic [DATA_SIZE-1:0] PH,
  input  logic [DATA_SIZE-1:0] PW,
  input  logic [DATA_SIZE-1:0] STRIDE,
  input  logic                 ready,
  output logic                 valid,
  output logic [LOOP_BIT-1:0]  mm,
  output logic [LOOP_BIT-1:0]  nirr,
  output logic [LOOP_BIT-1:0]  nicc,
  output logic [LOOP_BIT-1:0]  niro,
  output logic [LOOP_BIT-1:0]  nico,
  output logic [LOOP_BIT-1:0]  ii,
  output logic [LOOP_BIT-1:0]  jj,
  output logic                 win_first,
  output logic                 win_last,
  output logic                 busy,
  output logic                 done,
  output logic                 cfg_err
);

  localparam int unsigned CW = DATA_SIZE + 2;

  logic [1:0]           state_q, state_d;
  logic                 valid_q, valid_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 cfg_err_q, cfg_err_d;
  logic [DATA_SIZE-1:0] m_q, m_d, ph_q, ph_d, pw_q, pw_d;
  logic [CW-1:0]        stride_q, stride_d, np_q, np_d;
  logic [CW-1:0]        row_lim_q, row_lim_d, col_lim_q, col_lim_d;
  logic [LOOP_BIT-1:0]  mm_q, mm_d, ii_q, ii_d, jj_q, jj_d;

  logic [CW-1:0] row_val, col_val;
  logic          row_wrap_c, col_wrap_c;
  logic          cfg_bad_c, start_ok_c, acc_c;
  logic          jj_last_c, ii_last_c, mm_last_c;
  logic          adv_ii_c, adv_col_c, adv_row_c, adv_mm_c, last_c;

  // Config check on live inputs, widened so 2*nP+PH cannot overflow
  always_comb begin
    cfg_bad_c = (M == '0) || (PH == '0) || (PW == '0) || (STRIDE == '0)
             || (CW'(nIR) < (CW'(nP) + CW'(nP) + CW'(PH)))
             || (CW'(nIC) < (CW'(nP) + CW'(nP) + CW'(PW)));
  end

  assign start_ok_c = (state_q == ST_IDLE) && start && !cfg_bad_c;
  assign acc_c      = valid_q && ready;

  assign jj_last_c = (CW'(jj_q) == (CW'(pw_q) - CW'(1)));
  assign ii_last_c = (CW'(ii_q) == (CW'(ph_q) - CW'(1)));
  assign mm_last_c = (CW'(mm_q) == (CW'(m_q) - CW'(1)));

  // Carry chain, innermost first; every loop wraps to its reset value on the final beat
  assign adv_ii_c  = acc_c && jj_last_c;
  assign adv_col_c = adv_ii_c && ii_last_c;
  assign adv_row_c = adv_col_c && col_wrap_c;
  assign adv_mm_c  = adv_row_c && row_wrap_c;
  assign last_c    = adv_mm_c && mm_last_c;

  always_comb begin
    state_d   = state_q;
    cfg_err_d = 1'b0;
    m_d       = m_q;
    ph_d      = ph_q;
    pw_d      = pw_q;
    stride_d  = stride_q;
    np_d      = np_q;
    row_lim_d = row_lim_q;
    col_lim_d = col_lim_q;
    mm_d      = mm_q;
    ii_d      = ii_q;
    jj_d      = jj_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (cfg_bad_c) cfg_err_d = 1'b1;
          else           state_d   = ST_RUN;
        end
      end
      ST_RUN:  if (last_c) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    if (start_ok_c) begin
      m_d       = M;
      ph_d      = PH;
      pw_d      = PW;
      stride_d  = CW'(STRIDE);
      np_d      = CW'(nP);
      row_lim_d = CW'(nIR) - CW'(nP) - CW'(PH);
      col_lim_d = CW'(nIC) - CW'(nP) - CW'(PW);
      mm_d      = '0;
      ii_d      = '0;
      jj_d      = '0;
    end else begin
      if (acc_c)    jj_d = jj_last_c ? '0 : jj_q + LOOP_BIT'(1);
      if (adv_ii_c) ii_d = ii_last_c ? '0 : ii_q + LOOP_BIT'(1);
      if (adv_mm_c) mm_d = mm_last_c ? '0 : mm_q + LOOP_BIT'(1);
    end

    valid_d = (state_d == ST_RUN);
    busy_d  = (state_d == ST_RUN);
    done_d  = (state_q == ST_RUN) && (state_d == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      cfg_err_q <= 1'b0;
      m_q       <= '0;
      ph_q      <= '0;
      pw_q      <= '0;
      stride_q  <= '0;
      np_q      <= '0;
      row_lim_q <= '0;
      col_lim_q <= '0;
      mm_q      <= '0;
      ii_q      <= '0;
      jj_q      <= '0;
    end else begin
      state_q   <= state_d;
      valid_q   <= valid_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      cfg_err_q <= cfg_err_d;
      m_q       <= m_d;
      ph_q      <= ph_d;
      pw_q      <= pw_d;
      stride_q  <= stride_d;
      np_q      <= np_d;
      row_lim_q <= row_lim_d;
      col_lim_q <= col_lim_d;
      mm_q      <= mm_d;
      ii_q      <= ii_d;
      jj_q      <= jj_d;
    end
  end

  // np_d feeds init so a start loads the new padding in the same cycle it is latched
  maxp_win_cnt #(.CW(CW), .LB(LOOP_BIT)) u_col_cnt (
    .clk    (clk),
    .rst    (rst),
    .load   (start_ok_c),
    .adv    (adv_col_c),
    .init   (np_d),
    .step   (stride_q),
    .limit  (col_lim_q),
    .value  (col_val),
    .idx    (nico),
    .wrap_c (col_wrap_c)
  );

  maxp_win_cnt #(.CW(CW), .LB(LOOP_BIT)) u_row_cnt (
    .clk    (clk),
    .rst    (rst),
    .load   (start_ok_c),
    .adv    (adv_row_c),
    .init   (np_d),
    .step   (stride_q),
    .limit  (row_lim_q),
    .value  (row_val),
    .idx    (niro),
    .wrap_c (row_wrap_c)
  );

  assign valid     = valid_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign cfg_err   = cfg_err_q;
  assign mm        = mm_q;
  assign ii        = ii_q;
  assign jj        = jj_q;
  assign nirr      = LOOP_BIT'(row_val);
  assign nicc      = LOOP_BIT'(col_val);
  assign win_first = valid_q && (ii_q == '0) && (jj_q == '0);
  assign win_last  = valid_q && ii_last_c && jj_last_c;

endmodule

// File: tb/tb_maxp_loop_gen.sv
// Directed bench for maxp_loop_gen: nested-loop reference tuples, backpressure, config errors, abort by reset.
module tb_maxp_loop_gen;

  logic        clk = 1'b0;
  logic        rst, start, ready;
  logic [15:0] M, nIR, nIC, nP, PH, PW, STRIDE;
  logic        valid, win_first, win_last, busy, done, cfg_err;
  logic [11:0] mm, nirr, nicc, niro, nico, ii, jj;

  typedef struct {
    int mm, nirr, nicc, niro, nico, ii, jj;
    bit wf, wl;
  } tup_t;

  tup_t        exp_q[$];
  int          obs_mm_q[$];
  logic [85:0] last_obs;
  int          n_checks = 0;
  int          n_fail   = 0;

  always #5 clk = ~clk;

  maxp_loop_gen dut (
    .clk(clk), .rst(rst), .start(start),
    .M(M), .nIR(nIR), .nIC(nIC), .nP(nP), .PH(PH), .PW(PW), .STRIDE(STRIDE),
    .ready(ready), .valid(valid),
    .mm(mm), .nirr(nirr), .nicc(nicc), .niro(niro), .nico(nico), .ii(ii), .jj(jj),
    .win_first(win_first), .win_last(win_last),
    .busy(busy), .done(done), .cfg_err(cfg_err)
  );

  task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [85:0] obs_pack();
    return {mm, nirr, nicc, niro, nico, ii, jj, win_first, win_last};
  endfunction

  function automatic logic [85:0] exp_pack(input tup_t t);
    return {12'(t.mm), 12'(t.nirr), 12'(t.nicc), 12'(t.niro), 12'(t.nico),
            12'(t.ii), 12'(t.jj), t.wf, t.wl};
  endfunction

  task automatic set_cfg(input int m, nir, nic, np, ph, pw, s);
    M = 16'(m); nIR = 16'(nir); nIC = 16'(nic); nP = 16'(np);
    PH = 16'(ph); PW = 16'(pw); STRIDE = 16'(s);
  endtask

  // Reference sequence straight from the loop nest, using division for the output extent
  task automatic build(input int m, nir, nic, np, ph, pw, s);
    int oh, ow;
    tup_t t;
    exp_q.delete();
    oh = (nir - 2*np - ph) / s + 1;
    ow = (nic - 2*np - pw) / s + 1;
    for (int a = 0; a < m; a++)
      for (int r = 0; r < oh; r++)
        for (int c = 0; c < ow; c++)
          for (int i = 0; i < ph; i++)
            for (int j = 0; j < pw; j++) begin
              t.mm = a; t.nirr = np + r*s; t.nicc = np + c*s; t.niro = r; t.nico = c;
              t.ii = i; t.jj = j; t.wf = (i == 0 && j == 0); t.wl = (i == ph-1 && j == pw-1);
              exp_q.push_back(t);
            end
  endtask

  task automatic run(input string name, input int m, nir, nic, np, ph, pw, s,
                     input bit bp, input int exp_beats);
    int   nacc;
    bit   seen_done;
    bit   rdy;
    tup_t t;
    logic [3:0] pat;
    pat = 4'b1001;
    build(m, nir, nic, np, ph, pw, s);
    set_cfg(m, nir, nic, np, ph, pw, s);
    obs_mm_q.delete();
    start = 1'b1;
    step();
    start = 1'b0;
    chk({name, "_first_valid_busy"}, {valid, busy}, 2'b11);
    nacc = 0;
    seen_done = 1'b0;
    for (int cyc = 0; cyc < 4000 && !seen_done; cyc++) begin
      if (done) begin
        seen_done = 1'b1;
        chk({name, "_done_valid_busy"}, {valid, busy}, 2'b00);
        chk({name, "_beats"}, 96'(nacc), 96'(exp_beats));
        chk({name, "_done_idx"}, obs_pack(),
            {12'd0, 12'(np), 12'(np), 12'd0, 12'd0, 12'd0, 12'd0, 2'b00});
      end else if (valid) begin
        if (nacc < exp_q.size()) begin
          t = exp_q[nacc];
          chk($sformatf("%s_beat%0d", name, nacc), obs_pack(), exp_pack(t));
        end else begin
          chk({name, "_extra_beat"}, 96'(nacc), 96'(exp_q.size() - 1));
        end
        rdy = bp ? pat[cyc % 4] : 1'b1;
        ready = rdy;
        if (rdy) begin
          obs_mm_q.push_back(int'(mm));
          last_obs = obs_pack();
          nacc++;
        end
        step();
      end else begin
        chk({name, "_valid_gap"}, valid, 1'b1);
        step();
      end
    end
    if (!seen_done) chk({name, "_timeout_done"}, done, 1'b1);
    ready = 1'b1;
    step();
    chk({name, "_done_pulse_end"}, {done, busy, valid}, 3'b000);
  endtask

  task automatic bad_start(input string name, input int m, nir, nic, np, ph, pw, s);
    set_cfg(m, nir, nic, np, ph, pw, s);
    start = 1'b1;
    step();
    start = 1'b0;
    chk({name, "_cfg_err"}, {cfg_err, valid, busy, done}, 4'b1000);
    for (int k = 0; k < 6; k++) begin
      step();
      chk($sformatf("%s_quiet%0d", name, k), {cfg_err, valid, busy, done}, 4'b0000);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; ready = 1'b1;
    set_cfg(0, 0, 0, 0, 0, 0, 0);
    step();
    step();
    chk("reset_idx", obs_pack(), 86'd0);
    chk("reset_flags", {valid, busy, done, cfg_err}, 4'b0000);
    rst = 1'b0;
    step();

    run("t1", 1, 4, 4, 0, 2, 2, 2, 1'b0, 16);
    chk("t1_last_tuple", last_obs,
        {12'd0, 12'd2, 12'd2, 12'd1, 12'd1, 12'd1, 12'd1, 1'b0, 1'b1});

    run("t2", 1, 4, 4, 0, 2, 2, 1, 1'b0, 36);

    run("t3", 2, 6, 6, 1, 2, 2, 2, 1'b0, 32);
    chk("t3_mm_beat16", 96'(obs_mm_q[15]), 96'd0);
    chk("t3_mm_beat17", 96'(obs_mm_q[16]), 96'd1);

    run("t4bp", 1, 4, 4, 0, 2, 2, 2, 1'b1, 16);

    bad_start("e_pw", 1, 4, 4, 0, 2, 5, 2);
    bad_start("e_stride", 1, 4, 4, 0, 2, 2, 0);

    // Abort a run with reset after seven accepted beats
    set_cfg(1, 4, 4, 0, 2, 2, 2);
    start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 0; k < 7; k++) step();
    chk("abort_pre_valid", valid, 1'b1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("abort_reset", {obs_pack(), valid, busy, done, cfg_err}, 90'd0);
    for (int k = 0; k < 5; k++) begin
      step();
      chk($sformatf("abort_no_done%0d", k), {done, valid, busy}, 3'b000);
    end
    run("t5restart", 2, 6, 6, 1, 2, 2, 2, 1'b0, 32);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/maxp_loop_gen.md
Name: maxp_loop_gen

Overview:
- Parametrised, handshaked loop-index generator for the max-pool datapath. Successor to the fixed 1-step pooling loop counter.
- Walks feature map (mm) → output row → output column → window row (ii) → window column (jj).
- Adds over the previous generation: separate pool height/width, configurable stride, start/done handshake, backpressure, window first/last flags, config error detection.
- Sits between the layer controller (issues start + config) and the max-pool address generator / comparator (consumes one index tuple per accepted beat).

Parameters:
- DATA_SIZE, 16, width of configuration inputs.
- LOOP_BIT, 12, width of every index output.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; one clock, synchronous, active-high.
- start  in  1  one-cycle pulse; accepted only in IDLE.
- M  in  DATA_SIZE  number of feature maps.
- nIR  in  DATA_SIZE  input rows, including padding.
- nIC  in  DATA_SIZE  input columns, including padding.
- nP  in  DATA_SIZE  padding border width.
- PH  in  DATA_SIZE  pool window height.
- PW  in  DATA_SIZE  pool window width.
- STRIDE  in  DATA_SIZE  window step, same in both directions.
- ready  in  1  consumer accepts the current tuple.
- valid  out  1  tuple on index outputs is valid.
- mm, nirr, nicc, niro, nico, ii, jj  out  LOOP_BIT each  map, input window-origin row/col, output row/col, window row/col.
- win_first  out  1  valid beat with ii==0 && jj==0.
- win_last  out  1  valid beat with ii==PH-1 && jj==PW-1 (comparator writes result).
- busy  out  1  high in RUN.
- done  out  1  one-cycle pulse after final beat accepted.
- cfg_err  out  1  one-cycle pulse on rejected start.

Behaviour:
- Reset (synchronous):
  - state=IDLE.
  - All indices = 0 except nirr = nicc = latched nP (0 after reset).
  - valid, busy, done, cfg_err, win_first, win_last = 0.
- Start in IDLE:
  - Latch all config into internal registers; input changes during RUN are ignored.
- Config check, done in the start cycle:
  - Error if any of M, PH, PW, STRIDE is 0, or nIR < 2*nP+PH, or nIC < 2*nP+PW.
  - Compare with DATA_SIZE+2 bits.
  - On error: cfg_err pulses next cycle, state stays IDLE, no valid beats, done not asserted.
- Valid start: next cycle state=RUN, valid=1, tuple = (0, nP, nP, 0, 0, 0, 0).
- Advance rule:
  - Tuple advances only on the accept cycle (valid && ready).
  - When ready=0, the tuple and flags hold stable; no skipped or repeated tuples.
- Nesting per accept, innermost first:
  - jj: 0..PW-1.
  - ii: 0..PH-1.
  - Column: nicc += STRIDE, nico += 1. Wraps when nicc+STRIDE+PW > nIC-nP; on wrap nicc=nP, nico=0.
  - Row: same rule with nirr, niro, nIR, PH.
  - mm: 0..M-1.
- Last beat: accept while all five loops are at terminal values.
  - Next cycle: state=DONE, valid=0, done=1, indices return to their reset values.
  - Following cycle: IDLE.
- Beat count: M*OH*OW*PH*PW, where OH = (nIR-2nP-PH)/STRIDE+1 and OW likewise with nIC/PW. No divider is needed in RTL; the termination compares above produce this count.
- Index width: outputs are truncated to LOOP_BIT. Config guaranteeing indices < 2^LOOP_BIT is the controller's responsibility; no wrap detection.
- start in RUN or DONE: ignored, no effect.
- rst in any state: returns to IDLE in that cycle; no done pulse.
- win_first / win_last: combinational from the registered ii/jj and latched PH/PW, gated by valid. PH=PW=1 gives both high on every beat.
- FSM states: IDLE → RUN (valid start) → DONE (final accept) → IDLE.

Decomposition:
- Shared package/include: FSM state encodings (IDLE, RUN, DONE) and DATA_SIZE / LOOP_BIT defaults, alongside existing params.
- One natural sub-module: maxp_win_cnt. A generic wrap counter with inputs (adv, init, step, limit), outputs (value, wrap), and a parallel output-index counter. Instantiate it for the column and row loops; ii/jj/mm are plain wrap counters.

Test Plan:
- M=1, nIR=nIC=4, nP=0, PH=PW=2, STRIDE=2, ready=1 → 16 valid beats; last tuple (0,2,2,1,1,1,1) with win_last=1; done one cycle later; busy falls.
- Same config, STRIDE=1 → nicc/nirr ∈ {0,1,2}, niro/nico ∈ {0,1,2}; 36 beats.
- M=2, nIR=nIC=6, nP=1, PH=PW=2, STRIDE=2 → nirr/nicc ∈ {1,3}, niro/nico ∈ {0,1}; 32 beats; mm steps 0→1 at beat 17.
- Backpressure: first test with ready toggled 1,0,0,1 pseudo-randomly → identical tuple sequence; outputs stable while ready=0; total beats still 16.
- start with PW=5, nIC=4 → cfg_err pulse, valid never asserted, done=0. start with STRIDE=0 → same.
- rst asserted at beat 7 of a run, then a fresh start → sequence restarts at (0,nP,nP,0,0,0,0); no done pulse from the aborted run.
